// File: rtl/div_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_chk_pkg
// Description : Shared widths, operand-pair record and dout field split for
//               the divider result checker.
// Revision    : 1.0 - initial release
// ============================================================================
package div_chk_pkg;

    localparam int c_data_w = 8;
    localparam int c_quot_w = 8;
    localparam int c_rem_w  = 8;
    localparam int c_dout_w = 16;

    typedef struct packed {
        logic [c_data_w-1:0] dividend;
        logic [c_data_w-1:0] divisor;
    } operand_pair_t;

    typedef struct packed {
        logic [c_quot_w-1:0] quot;
        logic [c_rem_w-1:0]  rem;
    } dout_fields_t;

    // Quotient sits at the top of dout, remainder at the bottom.
    function automatic dout_fields_t split_dout(input logic [c_dout_w-1:0] dout);
        dout_fields_t f;
        f.quot = dout[c_dout_w-1 -: c_quot_w];
        f.rem  = dout[c_rem_w-1:0];
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_chk_fifo.sv
`default_nettype none
// ============================================================================
// Module      : div_chk_fifo
// Description : Synchronous FIFO, combinational head read, push allowed when
//               full if a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module div_chk_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indexes match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + {{c_aw{1'b0}}, 1'b1};
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{c_aw{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/div_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : div_result_checker
// Description : Passive checker for an AXI-stream divider: queues operand
//               pairs, verifies q*d + r == n and r < d on each dout beat.
// Revision    : 1.0 - initial release
// ============================================================================
module div_result_checker
    import div_chk_pkg::*;
#(
    parameter int DATA_W     = c_data_w,
    parameter int QUOT_W     = c_quot_w,
    parameter int REM_W      = c_rem_w,
    parameter int DOUT_W     = c_dout_w,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              s_axis_dividend_tvalid,
    input  logic [DATA_W-1:0] s_axis_dividend_tdata,
    input  logic              s_axis_divisor_tvalid,
    input  logic [DATA_W-1:0] s_axis_divisor_tdata,
    input  logic              m_axis_dout_tvalid,
    input  logic [DOUT_W-1:0] m_axis_dout_tdata,
    output logic              chk_valid,
    output logic              chk_pass,
    output logic              chk_fail,
    output logic              chk_div0,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic              ovf_err,
    output logic              unf_err,
    output logic              orphan_err
);

    localparam int c_prod_w = DATA_W + QUOT_W;
    localparam int c_sum_w  = c_prod_w + 1;

    operand_pair_t       w_push_pair;
    operand_pair_t       w_head;
    dout_fields_t        w_fields;
    logic                w_accept;
    logic                w_full;
    logic                w_empty;
    logic                w_pop_ok;
    logic [c_sum_w-1:0]  w_sum;
    logic                w_fail;

    logic                r_s1_valid;
    logic [c_prod_w-1:0] r_s1_prod;
    logic [c_prod_w-1:0] r_s1_rem;
    logic [DATA_W-1:0]   r_s1_dividend;
    logic [DATA_W-1:0]   r_s1_divisor;
    logic                r_s1_div0;

    assign w_accept             = s_axis_dividend_tvalid && s_axis_divisor_tvalid;
    assign w_push_pair.dividend = s_axis_dividend_tdata;
    assign w_push_pair.divisor  = s_axis_divisor_tdata;
    assign w_pop_ok             = m_axis_dout_tvalid && !w_empty;
    assign w_fields             = split_dout(m_axis_dout_tdata);

    div_chk_fifo #(
        .WIDTH ($bits(operand_pair_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst     (areset),
        .i_push  (w_accept),
        .i_data  (w_push_pair),
        .i_pop   (m_axis_dout_tvalid),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Stage 1: product and operand capture.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_s1_valid    <= 1'b0;
            r_s1_prod     <= '0;
            r_s1_rem      <= '0;
            r_s1_dividend <= '0;
            r_s1_divisor  <= '0;
            r_s1_div0     <= 1'b0;
        end else begin
            r_s1_valid    <= w_pop_ok;
            r_s1_prod     <= {{DATA_W{1'b0}}, w_fields.quot} *
                             {{QUOT_W{1'b0}}, w_head.divisor};
            r_s1_rem      <= {{(c_prod_w-REM_W){1'b0}}, w_fields.rem};
            r_s1_dividend <= w_head.dividend;
            r_s1_divisor  <= w_head.divisor;
            r_s1_div0     <= (w_head.divisor == '0);
        end
    end

    // Sum carries one extra bit so an oversized product cannot wrap into a match.
    assign w_sum  = {1'b0, r_s1_prod} + {1'b0, r_s1_rem};
    assign w_fail = (w_sum != {{(c_sum_w-DATA_W){1'b0}}, r_s1_dividend}) ||
                    (r_s1_rem >= {{QUOT_W{1'b0}}, r_s1_divisor});

    // Stage 2: verdict and saturating counters.
    always_ff @(posedge aclk) begin
        if (areset) begin
            chk_valid  <= 1'b0;
            chk_pass   <= 1'b0;
            chk_fail   <= 1'b0;
            chk_div0   <= 1'b0;
            pass_count <= '0;
            fail_count <= '0;
        end else begin
            chk_valid <= r_s1_valid;
            chk_div0  <= r_s1_valid && r_s1_div0;
            chk_fail  <= r_s1_valid && !r_s1_div0 && w_fail;
            chk_pass  <= r_s1_valid && !r_s1_div0 && !w_fail;
            if (r_s1_valid && !r_s1_div0) begin
                if (w_fail) begin
                    if (fail_count != {CNT_W{1'b1}})
                        fail_count <= fail_count + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    if (pass_count != {CNT_W{1'b1}})
                        pass_count <= pass_count + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            ovf_err    <= 1'b0;
            unf_err    <= 1'b0;
            orphan_err <= 1'b0;
        end else begin
            if (w_accept && w_full && !m_axis_dout_tvalid) ovf_err <= 1'b1;
            if (m_axis_dout_tvalid && w_empty)              unf_err <= 1'b1;
            if (s_axis_dividend_tvalid != s_axis_divisor_tvalid) orphan_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_result_checker
// Description : Directed self-checking bench for div_result_checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_result_checker;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_axis_dividend_tvalid;
    logic [7:0]  s_axis_dividend_tdata;
    logic        s_axis_divisor_tvalid;
    logic [7:0]  s_axis_divisor_tdata;
    logic        m_axis_dout_tvalid;
    logic [15:0] m_axis_dout_tdata;
    logic        chk_valid, chk_pass, chk_fail, chk_div0;
    logic [15:0] pass_count, fail_count;
    logic        ovf_err, unf_err, orphan_err;

    int n_checks = 0;
    int n_ok     = 0;
    int n_valid  = 0;
    int n_passp  = 0;

    logic [7:0] vd [18];
    logic [7:0] vs [18];

    always #5 aclk = ~aclk;

    div_result_checker u_dut (
        .aclk                   (aclk),
        .areset                 (areset),
        .s_axis_dividend_tvalid (s_axis_dividend_tvalid),
        .s_axis_dividend_tdata  (s_axis_dividend_tdata),
        .s_axis_divisor_tvalid  (s_axis_divisor_tvalid),
        .s_axis_divisor_tdata   (s_axis_divisor_tdata),
        .m_axis_dout_tvalid     (m_axis_dout_tvalid),
        .m_axis_dout_tdata      (m_axis_dout_tdata),
        .chk_valid              (chk_valid),
        .chk_pass               (chk_pass),
        .chk_fail               (chk_fail),
        .chk_div0               (chk_div0),
        .pass_count             (pass_count),
        .fail_count             (fail_count),
        .ovf_err                (ovf_err),
        .unf_err                (unf_err),
        .orphan_err             (orphan_err)
    );

    always @(negedge aclk) begin
        if (chk_valid) n_valid++;
        if (chk_valid && chk_pass) n_passp++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else
            n_ok++;
    endtask

    // Drive one cycle of stimulus, then land just after the next rising edge.
    task automatic cyc(input logic dv, input logic [7:0] dd, input logic sv,
                       input logic [7:0] sd, input logic ov, input logic [15:0] od);
        s_axis_dividend_tvalid = dv;
        s_axis_dividend_tdata  = dd;
        s_axis_divisor_tvalid  = sv;
        s_axis_divisor_tdata   = sd;
        m_axis_dout_tvalid     = ov;
        m_axis_dout_tdata      = od;
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 16'd0);
    endtask

    function automatic logic [15:0] good_dout(input int i);
        logic [7:0] q;
        logic [7:0] r;
        q = vd[i] / vs[i];
        r = vd[i] % vs[i];
        return {q, r};
    endfunction

    initial begin
        int v0;
        int p0;
        for (int i = 0; i < 18; i++) begin
            vd[i] = 8'(i * 13 + 1);
            vs[i] = 8'(i + 1);
        end

        areset = 1'b1;
        s_axis_dividend_tvalid = 1'b0;
        s_axis_dividend_tdata  = 8'd0;
        s_axis_divisor_tvalid  = 1'b0;
        s_axis_divisor_tdata   = 8'd0;
        m_axis_dout_tvalid     = 1'b0;
        m_axis_dout_tdata      = 16'd0;
        @(posedge aclk);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        check("rst_valid", chk_valid, 0);
        check("rst_counts", {pass_count, fail_count}, 0);
        check("rst_sticky", {ovf_err, unf_err, orphan_err}, 0);
        idle(1);
        check("post_rst_valid", chk_valid, 0);

        // 100/7 -> q=14 r=2
        cyc(1, 8'd100, 1, 8'd7, 0, 16'd0);
        cyc(0, 8'd0, 0, 8'd0, 1, {8'd14, 8'd2});
        idle(1);
        check("pass_flags", {chk_valid, chk_pass, chk_fail, chk_div0}, 4'b1100);
        check("pass_count1", pass_count, 1);
        idle(1);
        check("pulse_end", {chk_valid, chk_pass, chk_fail, chk_div0}, 4'b0000);

        // 15*7+2 = 107 != 100
        cyc(1, 8'd100, 1, 8'd7, 0, 16'd0);
        cyc(0, 8'd0, 0, 8'd0, 1, {8'd15, 8'd2});
        idle(1);
        check("fail_flags", {chk_valid, chk_pass, chk_fail, chk_div0}, 4'b1010);
        check("fail_count1", fail_count, 1);

        // 2*3+3 = 9 but remainder not below divisor
        cyc(1, 8'd9, 1, 8'd3, 0, 16'd0);
        cyc(0, 8'd0, 0, 8'd0, 1, {8'd2, 8'd3});
        idle(1);
        check("rem_ge_flags", {chk_valid, chk_pass, chk_fail, chk_div0}, 4'b1010);
        check("fail_count2", fail_count, 2);

        cyc(1, 8'd5, 1, 8'd0, 0, 16'd0);
        cyc(0, 8'd0, 0, 8'd0, 1, 16'h1234);
        idle(1);
        check("div0_flags", {chk_valid, chk_pass, chk_fail, chk_div0}, 4'b1001);
        check("div0_counts", {pass_count, fail_count}, {16'd1, 16'd2});
        check("sticky_clean", {ovf_err, unf_err, orphan_err}, 0);

        // Fill the FIFO, then push and pop together while full.
        p0 = n_passp;
        for (int i = 0; i < 16; i++) cyc(1, vd[i], 1, vs[i], 0, 16'd0);
        check("full_no_ovf", ovf_err, 0);
        cyc(1, vd[16], 1, vs[16], 1, good_dout(0));
        check("simul_no_ovf", ovf_err, 0);
        cyc(1, vd[17], 1, vs[17], 0, 16'd0);
        check("ovf_set", ovf_err, 1);
        check("simul_pass", {chk_valid, chk_pass, chk_fail, chk_div0}, 4'b1100);
        for (int k = 0; k < 16; k++) begin
            cyc(0, 8'd0, 0, 8'd0, 1, good_dout(k + 1));
            if (k >= 1) check($sformatf("drain_%0d", k - 1), {chk_valid, chk_pass}, 2'b11);
        end
        idle(1);
        check("drain_last", {chk_valid, chk_pass}, 2'b11);
        idle(1);
        check("drain_pulses", n_passp - p0, 17);
        check("drain_count", pass_count, 18);
        check("drain_idle", chk_valid, 0);

        // FIFO now empty: the dropped 17th pair is never checked.
        v0 = n_valid;
        check("unf_clear", unf_err, 0);
        cyc(0, 8'd0, 0, 8'd0, 1, good_dout(17));
        idle(3);
        check("unf_set", unf_err, 1);
        check("unf_no_valid", n_valid - v0, 0);
        check("unf_counts", {pass_count, fail_count}, {16'd18, 16'd2});

        // Reset with pairs queued and a result mid-pipeline.
        v0 = n_valid;
        for (int i = 0; i < 4; i++) cyc(1, vd[i], 1, vs[i], 0, 16'd0);
        cyc(0, 8'd0, 0, 8'd0, 1, good_dout(0));
        areset = 1'b1;
        idle(1);
        areset = 1'b0;
        idle(3);
        check("rst2_no_valid", n_valid - v0, 0);
        check("rst2_counts", {pass_count, fail_count}, 0);
        check("rst2_sticky", {ovf_err, unf_err, orphan_err}, 0);

        // Lone dividend is flagged and not queued.
        cyc(1, 8'd5, 0, 8'd0, 0, 16'd0);
        check("orphan_set", orphan_err, 1);
        cyc(0, 8'd0, 0, 8'd0, 1, 16'd0);
        idle(2);
        check("orphan_not_pushed", {unf_err, 1'b0}, 2'b10);
        check("orphan_no_valid", n_valid - v0, 0);

        // 15*16+15 = 255
        cyc(1, 8'd255, 1, 8'd16, 0, 16'd0);
        cyc(0, 8'd0, 0, 8'd0, 1, {8'd15, 8'd15});
        idle(1);
        check("final_flags", {chk_valid, chk_pass, chk_fail, chk_div0}, 4'b1100);
        check("final_count", pass_count, 1);

        $display("%0d/%0d checks passed", n_ok, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
